// File: rtl/instr_enc_pkg.sv
// Shared types, RV32I opcode constants and the field-to-word encoder
// used by the instruction encoder.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        OP_R     = 3'd0,
        OP_I     = 3'd1,
        OP_LW    = 3'd2,
        OP_SW    = 3'd3,
        OP_BEQ   = 3'd4,
        OP_LUI   = 3'd5,
        OP_AUIPC = 3'd6,
        OP_ILL   = 3'd7
    } op_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [31:0] word;
        logic        illegal;
    } enc_t;

    function automatic enc_t encode(input op_t         op,
                                    input logic [2:0]  f3,
                                    input logic        alt,
                                    input logic [4:0]  rd,
                                    input logic [4:0]  rs1,
                                    input logic [4:0]  rs2,
                                    input logic [31:0] imm);
        enc_t e;
        e.word    = '0;
        e.illegal = 1'b0;
        case (op)
            OP_R:     e.word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_R};
            OP_I: begin
                // Shift-immediates carry the shamt in [24:20] and alt in bit 30
                if (f3 == 3'b001 || f3 == 3'b101)
                    e.word = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OPC_I};
                else
                    e.word = {imm[11:0], rs1, f3, rd, OPC_I};
            end
            OP_LW:    e.word = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
            OP_SW:    e.word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
            OP_BEQ: begin
                e.word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
                e.illegal = imm[0];
            end
            OP_LUI:   e.word = {imm[31:12], rd, OPC_LUI};
            OP_AUIPC: e.word = {imm[31:12], rd, OPC_AUIPC};
            default:  e.illegal = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Count-based synchronous FIFO; the read port shows the head entry
// (zero when empty) so the consumer sees data the cycle after a push.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-level request to instruction-word encoder with an output
// FIFO and a word-aligned address counter for instruction-memory loading.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int                DEPTH      = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);
    enc_t enc;
    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;

    assign enc       = encode(op_t'(req_op), req_funct3, req_alt, req_rd,
                              req_rs1, req_rs2, req_imm);
    // Held low while reset is asserted so nothing is accepted during reset
    assign req_ready = !RST && !full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && !enc.illegal;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (enc.word),
        .pop       (pop),
        .pop_data  (out_instr),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_addr <= START_ADDR;
            err      <= 1'b0;
        end else begin
            err <= accept && enc.illegal;
            if (pop) out_addr <= out_addr + ADDR_W'(4);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a shift-and-or
// reference encoder and an expected-word queue.
module tb_instr_encoder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_alt = 1'b0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = 32'd0;

    instr_encoder #(.DEPTH(4), .ADDR_W(32), .START_ADDR(32'd0)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_funct3(req_funct3), .req_alt(req_alt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Reference: {illegal, word} built with shifts and masks from the format tables
    function automatic logic [32:0] ref_enc(input int op, input int f3, input int alt,
                                            input int rd, input int rs1, input int rs2,
                                            input logic [31:0] imm);
        logic [31:0] w;
        logic        ill;
        logic [31:0] base;
        ill  = 1'b0;
        base = (rs1 << 15) | (rd << 7);
        case (op)
            0: w = (alt << 30) | (rs2 << 20) | base | (f3 << 12) | 32'd51;
            1: if (f3 == 1 || f3 == 5)
                   w = (alt << 30) | ((imm & 32'd31) << 20) | base | (f3 << 12) | 32'd19;
               else
                   w = ((imm & 32'hFFF) << 20) | base | (f3 << 12) | 32'd19;
            2: w = ((imm & 32'hFFF) << 20) | base | (2 << 12) | 32'd3;
            3: w = (((imm >> 5) & 32'd127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((imm & 32'd31) << 7) | 32'd35;
            4: begin
                w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25)
                    | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'd15) << 8)
                    | (((imm >> 11) & 32'd1) << 7) | 32'd99;
                ill = imm[0];
            end
            5: w = (imm & 32'hFFFFF000) | (rd << 7) | 32'd55;
            6: w = (imm & 32'hFFFFF000) | (rd << 7) | 32'd23;
            default: begin w = 32'd0; ill = 1'b1; end
        endcase
        return {ill, w};
    endfunction

    // Output monitor: every handshaken word must match the expected queue
    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            exp_addr = 32'd0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_instr, 32'hDEAD_BEEF);
            end else begin
                check("instr", out_instr, exp_q.pop_front());
                check("addr", out_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
        end
    end

    task automatic send(input int op, input int f3, input int alt, input int rd,
                        input int rs1, input int rs2, input logic [31:0] imm,
                        input logic [31:0] exp_w, input logic exp_ill, input bit rand_bp);
        bit done = 0;
        req_op = 3'(op); req_funct3 = 3'(f3); req_alt = 1'(alt);
        req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge CLK);
            if (req_ready) done = 1;
            @(posedge CLK); #1;
        end
        req_valid = 1'b0;
        if (!done) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            if (!exp_ill) exp_q.push_back(exp_w);
            @(negedge CLK);
            check("err", {31'd0, err}, {31'd0, exp_ill});
        end
        @(posedge CLK); #1;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge CLK); #1;
            if (exp_q.size() == 0 && !out_valid) ok = 1;
        end
        check("drain_done", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [32:0] r;
        int op, f3, alt, rd, rs1, rs2;
        logic [31:0] imm;

        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Directed encodings from hand-computed words
        out_ready = 1'b1;
        send(0, 0, 0, 3, 1, 2, 32'd0,          32'h002081B3, 1'b0, 0);
        send(0, 0, 1, 3, 1, 2, 32'd0,          32'h402081B3, 1'b0, 0);
        send(2, 0, 0, 5, 2, 0, 32'hFFFFFFFC,   32'hFFC12283, 1'b0, 0);
        send(3, 0, 0, 0, 2, 6, 32'd8,          32'h00612423, 1'b0, 0);
        send(4, 0, 0, 0, 1, 2, 32'd16,         32'h00208863, 1'b0, 0);
        send(5, 0, 0, 7, 0, 0, 32'h12345000,   32'h123453B7, 1'b0, 0);
        wait_drain();

        // Rejections: consumed, err pulses one cycle, nothing enqueued
        send(7, 0, 0, 1, 1, 1, 32'd0, 32'd0, 1'b1, 0);
        check("ill_err_clear", {31'd0, err}, 32'd0);
        check("ill_no_valid", {31'd0, out_valid}, 32'd0);
        send(4, 0, 0, 0, 1, 2, 32'd3, 32'd0, 1'b1, 0);
        check("beq_err_clear", {31'd0, err}, 32'd0);
        check("beq_no_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: four fill the FIFO, the fifth waits
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            imm = $urandom;
            r = ref_enc(1, 0, 0, k + 1, k + 2, 0, imm);
            send(1, 0, 0, k + 1, k + 2, 0, imm, r[31:0], r[32], 0);
        end
        r = ref_enc(0, 4, 0, 9, 10, 11, 32'd0);
        req_op = 3'd0; req_funct3 = 3'd4; req_alt = 1'b0;
        req_rd = 5'd9; req_rs1 = 5'd10; req_rs2 = 5'd11; req_valid = 1'b1;
        @(negedge CLK);
        check("full_ready_low", {31'd0, req_ready}, 32'd0);
        check("full_head_instr", out_instr, exp_q[0]);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("hold_instr", out_instr, exp_q[0]);
        check("hold_addr", out_addr, 32'd0);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        send(0, 4, 0, 9, 10, 11, 32'd0, r[31:0], r[32], 0);
        wait_drain();
        check("addr_after_five", out_addr, 32'd20);

        // Reset while words are buffered mid-drain
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r = ref_enc(5, 0, 0, k, 0, 0, 32'h000AB000 + 32'(k << 12));
            send(5, 0, 0, k, 0, 0, 32'h000AB000 + 32'(k << 12), r[31:0], r[32], 0);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_instr", out_instr, 32'd0);
        check("midrst_addr", out_addr, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        out_ready = 1'b1;
        r = ref_enc(6, 0, 0, 4, 0, 0, 32'hFEDCB123);
        send(6, 0, 0, 4, 0, 0, 32'hFEDCB123, r[31:0], r[32], 0);
        wait_drain();
        check("post_rst_addr", out_addr, 32'd4);

        // Randomized requests with random output backpressure
        for (int k = 0; k < 60; k++) begin
            op  = $urandom_range(0, 7);
            f3  = $urandom_range(0, 7);
            alt = $urandom_range(0, 1);
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            imm = $urandom;
            r = ref_enc(op, f3, alt, rd, rs1, rs2, imm);
            send(op, f3, alt, rd, rs1, rs2, imm, r[31:0], r[32], 1);
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
